// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit for the execute stage. Multiplies complete after MUL_LATENCY
// cycles; divides use a restoring divider and complete WIDTH+1 cycles after the start is accepted.
module muldiv_unit #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             ok,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = 7;

  // Handshake: a start is taken only in a cycle where busy=0 and flush=0; the requester holds
  // start until then. ok is a one-cycle pulse marking the cycle in which hi/lo carry a new result.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DIVFIX} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     rem_q, rem_d, quot_q, quot_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic                 neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, dzero_q, dzero_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 ok_q, ok_d;

  logic                 is_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0]   a_ext, b_ext, mul_full;
  logic [WIDTH-1:0]     a_mag, b_mag, quot_fix, rem_fix;
  logic [2*WIDTH-1:0]   step_first, step_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits. Returns {rem, quot}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quot,
                                                  input logic [WIDTH-1:0] dvsr);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    shifted = {rem, quot[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr};
    if (!diff[WIDTH]) div_step = {diff[WIDTH-1:0], quot[WIDTH-2:0], 1'b1};
    else              div_step = {shifted[WIDTH-1:0], quot[WIDTH-2:0], 1'b0};
  endfunction

  assign is_signed  = ~op[0];
  assign a_neg      = is_signed & a[WIDTH-1];
  assign b_neg      = is_signed & b[WIDTH-1];
  assign a_ext      = {{WIDTH{a_neg}}, a};
  assign b_ext      = {{WIDTH{b_neg}}, b};
  assign mul_full   = a_ext * b_ext;
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign step_first = div_step('0, a_mag, b_mag);
  assign step_next  = div_step(rem_q, quot_q, dvsr_q);
  assign quot_fix   = neg_quot_q ? -quot_q : quot_q;
  assign rem_fix    = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvsr_d     = dvsr_q;
    dvnd_d     = dvnd_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dzero_d    = dzero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    ok_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!op[1]) begin
            if (MUL_LATENCY == 1) begin
              {hi_d, lo_d} = mul_full;
              ok_d         = 1'b1;
            end else begin
              prod_d  = mul_full;
              cnt_d   = CW'(MUL_LATENCY - 1);
              state_d = MUL;
            end
          end else begin
            // The first quotient bit is produced at acceptance, so cnt counts the remaining steps.
            {rem_d, quot_d} = step_first;
            dvsr_d     = b_mag;
            dvnd_d     = a;
            neg_quot_d = a_neg ^ b_neg;
            neg_rem_d  = a_neg;
            dzero_d    = (b == '0);
            cnt_d      = CW'(WIDTH - 1);
            state_d    = DIV;
          end
        end
      end
      MUL: begin
        if (cnt_q == CW'(1)) begin
          {hi_d, lo_d} = prod_q;
          ok_d         = 1'b1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DIV: begin
        {rem_d, quot_d} = step_next;
        cnt_d           = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DIVFIX;
      end
      DIVFIX: begin
        if (dzero_q) begin
          hi_d = dvnd_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quot_fix;
        end
        ok_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      ok_d    = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvsr_q     <= '0;
      dvnd_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dzero_q    <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      ok_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvsr_q     <= dvsr_d;
      dvnd_q     <= dvnd_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dzero_q    <= dzero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      ok_q       <= ok_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign ok   = ok_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit/latency-2 instance and a 16-bit/latency-1 instance driven with
// directed vectors; expected results are queued at issue and checked by per-instance monitors.
module tb_muldiv_unit;

  localparam int W0 = 32, L0 = 2, W1 = 16, L1 = 1;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst0 = 1'b1, start0 = 1'b0, flush0 = 1'b0, busy0, ok0;
  logic [1:0]    op0 = '0;
  logic [W0-1:0] a0 = '0, b0 = '0, hi0, lo0;
  logic          rst1 = 1'b1, start1 = 1'b0, flush1 = 1'b0, busy1, ok1;
  logic [1:0]    op1 = '0;
  logic [W1-1:0] a1 = '0, b1 = '0, hi1, lo1;

  muldiv_unit #(.WIDTH(W0), .MUL_LATENCY(L0)) dut0 (
    .clk(clk), .reset(rst0), .start(start0), .op(op0), .a(a0), .b(b0), .flush(flush0),
    .busy(busy0), .ok(ok0), .hi(hi0), .lo(lo0));

  muldiv_unit #(.WIDTH(W1), .MUL_LATENCY(L1)) dut1 (
    .clk(clk), .reset(rst1), .start(start1), .op(op1), .a(a1), .b(b1), .flush(flush1),
    .busy(busy1), .ok(ok1), .hi(hi1), .lo(lo1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // scoreboard: {ok cycle, hi, lo}
  logic [95:0] exp0_q[$];
  logic [63:0] exp1_q[$];
  logic [95:0] e0;
  logic [63:0] e1;
  logic [W0-1:0] held_hi0 = '0, held_lo0 = '0;
  logic [W1-1:0] held_hi1 = '0, held_lo1 = '0;

  always @(negedge clk) begin
    if (rst0) begin
      held_hi0 = '0;
      held_lo0 = '0;
    end else if (ok0) begin
      if (exp0_q.size() == 0) begin
        check("ok0_unexpected", 64'(ok0), 64'(0));
      end else begin
        e0 = exp0_q.pop_front();
        check("ok0_cycle", 64'(cyc), 64'(e0[95:64]));
        check("hi0", 64'(hi0), 64'(e0[63:32]));
        check("lo0", 64'(lo0), 64'(e0[31:0]));
        held_hi0 = e0[63:32];
        held_lo0 = e0[31:0];
      end
    end else begin
      check("hold_hi0", 64'(hi0), 64'(held_hi0));
      check("hold_lo0", 64'(lo0), 64'(held_lo0));
    end
  end

  always @(negedge clk) begin
    if (rst1) begin
      held_hi1 = '0;
      held_lo1 = '0;
    end else if (ok1) begin
      if (exp1_q.size() == 0) begin
        check("ok1_unexpected", 64'(ok1), 64'(0));
      end else begin
        e1 = exp1_q.pop_front();
        check("ok1_cycle", 64'(cyc), 64'(e1[63:32]));
        check("hi1", 64'(hi1), 64'(e1[31:16]));
        check("lo1", 64'(lo1), 64'(e1[15:0]));
        held_hi1 = e1[31:16];
        held_lo1 = e1[15:0];
      end
    end else begin
      check("hold_hi1", 64'(hi1), 64'(held_hi1));
      check("hold_lo1", 64'(lo1), 64'(held_lo1));
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run0(input logic [1:0] op, input logic [W0-1:0] a, input logic [W0-1:0] b,
                      input logic [W0-1:0] hi_e, input logic [W0-1:0] lo_e);
    int lat;
    lat = op[1] ? W0 + 1 : L0;
    start0 = 1'b1; op0 = op; a0 = a; b0 = b;
    exp0_q.push_back({32'(cyc + lat), hi_e, lo_e});
    tick;
    start0 = 1'b0;
    repeat (lat - 2) tick;
    check("busy0_last", 64'(busy0), 64'(1));
    tick;
    check("busy0_okcycle", 64'(busy0), 64'(0));
  endtask

  task automatic run1(input logic [1:0] op, input logic [W1-1:0] a, input logic [W1-1:0] b,
                      input logic [W1-1:0] hi_e, input logic [W1-1:0] lo_e);
    int lat;
    lat = op[1] ? W1 + 1 : L1;
    start1 = 1'b1; op1 = op; a1 = a; b1 = b;
    exp1_q.push_back({32'(cyc + lat), hi_e, lo_e});
    tick;
    start1 = 1'b0;
    check("busy1_first", 64'(busy1), (lat > 1) ? 64'(1) : 64'(0));
    repeat (lat - 1) tick;
    check("busy1_okcycle", 64'(busy1), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with start held high: nothing may launch
    start0 = 1'b1; op0 = OP_MULT; a0 = 32'd3; b0 = 32'd3;
    start1 = 1'b1; op1 = OP_MULT; a1 = 16'd3; b1 = 16'd3;
    repeat (2) tick;
    rst0 = 1'b0; rst1 = 1'b0; start0 = 1'b0; start1 = 1'b0;
    check("rst_hi0", 64'(hi0), 64'(0));
    check("rst_lo0", 64'(lo0), 64'(0));
    check("rst_ok0", 64'(ok0), 64'(0));
    check("rst_busy0", 64'(busy0), 64'(0));
    check("rst_busy1", 64'(busy1), 64'(0));
    repeat (3) tick;

    run0(OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run0(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run0(OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000);
    run0(OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run0(OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);
    run0(OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run0(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run0(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);
    run0(OP_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF);
    run0(OP_DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF);

    // flush mid-divide at cycle 10, new start accepted in cycle 11
    start0 = 1'b1; op0 = OP_DIV; a0 = 32'd1000; b0 = 32'd3;
    tick;
    start0 = 1'b0;
    repeat (9) tick;
    flush0 = 1'b1;
    tick;
    flush0 = 1'b0;
    check("flush_busy0", 64'(busy0), 64'(0));
    run0(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

    // flush on the cycle the multiply result would be written
    start0 = 1'b1; op0 = OP_MULTU; a0 = 32'd9; b0 = 32'd9;
    tick;
    start0 = 1'b0;
    flush0 = 1'b1;
    tick;
    flush0 = 1'b0;
    check("flushwr_busy0", 64'(busy0), 64'(0));
    repeat (3) tick;

    // start and flush together in idle
    start0 = 1'b1; flush0 = 1'b1; op0 = OP_MULTU; a0 = 32'd2; b0 = 32'd2;
    tick;
    start0 = 1'b0; flush0 = 1'b0;
    check("startflush_busy0", 64'(busy0), 64'(0));
    repeat (3) tick;

    // reset mid-divide
    start0 = 1'b1; op0 = OP_DIV; a0 = 32'd50; b0 = 32'd5;
    tick;
    start0 = 1'b0;
    repeat (4) tick;
    rst0 = 1'b1;
    exp0_q.delete();
    tick;
    rst0 = 1'b0;
    check("midrst_hi0", 64'(hi0), 64'(0));
    check("midrst_lo0", 64'(lo0), 64'(0));
    check("midrst_busy0", 64'(busy0), 64'(0));
    run0(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    // 16-bit, single-cycle multiply instance
    run1(OP_MULT,  16'h8000, 16'h8000, 16'h4000, 16'h0000);
    run1(OP_MULTU, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001);
    run1(OP_MULT,  16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE);
    run1(OP_DIV,   16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD);
    run1(OP_DIVU,  16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC);

    repeat (3) tick;
    check("queue0_empty", 64'(exp0_q.size()), 64'(0));
    check("queue1_empty", 64'(exp1_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
